// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  // Redirect sources, ordered so that a larger code wins.
  typedef enum logic [1:0] {
    REDIR_NONE   = 2'd0,
    REDIR_BRANCH = 2'd1,
    REDIR_MRET   = 2'd2,
    REDIR_TRAP   = 2'd3
  } redir_src_t;

  // Priority trap > mret > branch.
  function automatic redir_src_t redir_pick(input logic trap, input logic mret,
                                            input logic branch);
    if (trap)        return REDIR_TRAP;
    else if (mret)   return REDIR_MRET;
    else if (branch) return REDIR_BRANCH;
    else             return REDIR_NONE;
  endfunction

  // Instruction fetches are word aligned.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_ctrl_pc.sv
// Architectural PC register; the reset address is the boot PC.
module program_counter #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_in,
  output logic [31:0] pc
);

  // Load the next-PC value every cycle; holding is done by feeding pc back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= RESET_ADDR;
    else        pc <= data_in;
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage sequencer: owns the PC, runs the I-memory req/ack handshake,
// buffers one instruction toward decode and kills fetches made stale by redirects.
module fetch_pc_ctrl #(
  parameter int unsigned MAX_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        trap_valid,
  input  logic [31:0] trap_vector,
  input  logic        mret_valid,
  input  logic [31:0] mepc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready,
  output logic [31:0] pc_current,
  output logic        fetch_err
);
  import fetch_pkg::*;

  localparam bit          TIMEOUT_EN = (MAX_WAIT != 0);
  localparam logic [7:0]  WAIT_LAST  = (MAX_WAIT == 0) ? 8'd0 : 8'(MAX_WAIT - 1);

  state_t      state;
  redir_src_t  redir_src;
  logic        redir;
  logic [31:0] redir_raw;
  logic [31:0] redir_target;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] req_addr;
  logic        req_hold;
  logic        kill;
  logic        capture;
  logic        timeout;
  logic [7:0]  wait_cnt;

  // Pick the winning redirect and align its target.
  always_comb begin
    redir_src = redir_pick(trap_valid, mret_valid, branch_taken);
    redir     = (redir_src != REDIR_NONE);
    case (redir_src)
      REDIR_TRAP:   redir_raw = trap_vector;
      REDIR_MRET:   redir_raw = mepc;
      REDIR_BRANCH: redir_raw = branch_target;
      default:      redir_raw = '0;
    endcase
    redir_target = align_word(redir_raw);
  end

  // Next-PC mux: redirect beats sequential advance on a good capture.
  always_comb begin
    capture = (state == FETCH) && imem_req && imem_ack && !kill && !redir;
    timeout = TIMEOUT_EN && (state == FETCH) && imem_req && !imem_ack &&
              (wait_cnt == WAIT_LAST);
    pc_next = pc;
    if (redir)        pc_next = redir_target;
    else if (capture) pc_next = pc + PC_STEP;
  end

  program_counter #(.RESET_ADDR(32'h0000_0000)) u_pc (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_in (pc_next),
    .pc      (pc)
  );

  // The pc register moves to a redirect target at once, so an outstanding
  // request presents the address latched on its first cycle instead.
  assign imem_addr  = req_hold ? req_addr : pc;
  assign pc_current = pc;

  // Fetch FSM with registered handshake, buffer and error outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      req_hold  <= 1'b0;
      req_addr  <= '0;
      kill      <= 1'b0;
      wait_cnt  <= '0;
      if_valid  <= 1'b0;
      if_pc     <= '0;
      if_instr  <= '0;
      fetch_err <= 1'b0;
    end else begin
      fetch_err <= 1'b0;
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
          req_hold <= 1'b0;
        end
        FETCH: begin
          if (!imem_req) begin
            // One idle cycle after a timeout; re-issue from pc next cycle.
            imem_req <= 1'b1;
          end else if (imem_ack) begin
            wait_cnt <= '0;
            req_hold <= 1'b0;
            kill     <= 1'b0;
            if (!kill && !redir) begin
              if_instr <= imem_rdata;
              if_pc    <= pc;
              if_valid <= 1'b1;
              imem_req <= 1'b0;
              state    <= FULL;
            end
          end else if (timeout) begin
            // Abandon the request; pc still names the address to fetch.
            wait_cnt  <= '0;
            fetch_err <= 1'b1;
            imem_req  <= 1'b0;
            req_hold  <= 1'b0;
            kill      <= 1'b0;
          end else begin
            if (TIMEOUT_EN) wait_cnt <= wait_cnt + 8'd1;
            if (!req_hold) begin
              req_addr <= pc;
              req_hold <= 1'b1;
            end
            if (redir) kill <= 1'b1;
          end
        end
        FULL: begin
          if (redir || if_ready) begin
            if_valid <= 1'b0;
            imem_req <= 1'b1;
            state    <= FETCH;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
